// File: rtl/pe_array_router_pkg.sv
// Shared types and lane-width helpers for the PE-array data-in router.
package pe_array_router_pkg;

    typedef enum logic {
        SRC_DUMMY = 1'b0,
        SRC_BUF   = 1'b1
    } src_e;

    // Wide enough for any practical row shift; unused upper bits stay zero.
    localparam int unsigned CFG_SHIFT_W = 8;

    typedef struct packed {
        src_e                   act_src;
        logic [CFG_SHIFT_W-1:0] row_shift;
        src_e                   w_src;
    } router_cfg_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } router_state_e;

    function automatic int unsigned act_lane_w(input int unsigned act_width);
        return act_width + 1;
    endfunction

    function automatic int unsigned bpr_w(input int unsigned weight_width);
        return ((weight_width + 1) / 2) * 3;
    endfunction

    localparam int unsigned DEF_ACT_LANE_W = act_lane_w(16);
    localparam int unsigned DEF_BPR_W      = bpr_w(16);

endpackage

// File: rtl/pe_act_skid_buffer.sv
// Two-entry registered skid buffer with valid/ready on both sides.
module pe_act_skid_buffer #(
    parameter int unsigned Width = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [Width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [Width-1:0] mem_q [2];
    logic             wr_q;
    logic             rd_q;
    logic [1:0]       cnt_q;
    logic             push;
    logic             pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rd_q];
    assign count     = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= in_data;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/pe_array_data_in_router.sv
// Registered, handshaked router of activations and weight sets into the PE array.
// Optional ROUTER_PERF_CNT_EN adds saturating beat/stall/drain performance counters.
module pe_array_data_in_router
    import pe_array_router_pkg::*;
#(
    parameter int unsigned NUM_PE_ROW    = 16,
    parameter int unsigned NUM_PE_COL    = 16,
    parameter int unsigned NB_TAPS       = 11,
    parameter int unsigned ACT_WIDTH     = 16,
    parameter int unsigned WEIGHT_WIDTH  = 16,
    parameter int unsigned ETC_WIDTH     = 4,
    parameter int unsigned MAX_ROW_SHIFT = 3,
    localparam int unsigned SHW  = $clog2(MAX_ROW_SHIFT + 1),
    localparam int unsigned AL   = act_lane_w(ACT_WIDTH),
    localparam int unsigned BPRW = bpr_w(WEIGHT_WIDTH),
    localparam int unsigned ARW  = NUM_PE_ROW * AL,
    localparam int unsigned WRW  = NUM_PE_COL * WEIGHT_WIDTH * NB_TAPS,
    localparam int unsigned BRW  = NUM_PE_COL * BPRW * NB_TAPS,
    localparam int unsigned ERW  = NUM_PE_COL * ETC_WIDTH * NB_TAPS,
    localparam int unsigned SRW  = NUM_PE_COL * AL
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic           cfg_act_src,
    input  logic [SHW-1:0] cfg_row_shift,
    input  logic           cfg_w_src,
    output logic           cfg_err,
    input  logic [ARW-1:0] act_dummy_in,
    input  logic [ARW-1:0] act_buf_in,
    input  logic           act_in_valid,
    output logic           act_in_ready,
    output logic [ARW-1:0] pe_act_out,
    output logic           pe_act_valid,
    input  logic           pe_act_ready,
    input  logic [WRW-1:0] w_dummy_reg,
    input  logic [BRW-1:0] w_dummy_bpr,
    input  logic [ERW-1:0] w_dummy_etc,
    input  logic [SRW-1:0] w_dummy_shadow,
    input  logic [WRW-1:0] w_buf_reg,
    input  logic [BRW-1:0] w_buf_bpr,
    input  logic [ERW-1:0] w_buf_etc,
    input  logic [SRW-1:0] w_buf_shadow,
    input  logic           w_in_valid,
    output logic           w_in_ready,
    output logic [WRW-1:0] pe_wreg,
    output logic [BRW-1:0] pe_wbpr,
    output logic [ERW-1:0] pe_wetc,
    output logic [SRW-1:0] pe_shadow_afifo_in,
    output logic           pe_w_load
`ifdef ROUTER_PERF_CNT_EN
    ,
    output logic [31:0]    perf_act_beats,
    output logic [31:0]    perf_act_stalls,
    output logic [31:0]    perf_cfg_drain
`endif
);

    router_state_e state_q, state_d;
    router_cfg_t   cfg_q, cfg_d;
    logic          cfg_err_q;
    logic          cfg_take;
    logic          cfg_hs;
    logic          shift_over;
    logic [SHW-1:0] shift_clamped;

    logic           act_gate;
    logic           act_hs;
    logic           skid_in_ready;
    logic [1:0]     skid_count;
    logic [ARW-1:0] routed;

    logic           w_hs;
    logic           w_load_q;
    logic [WRW-1:0] wreg_q;
    logic [BRW-1:0] wbpr_q;
    logic [ERW-1:0] wetc_q;
    logic [SRW-1:0] shadow_q;

    // Config request handling and clamping.
    assign shift_over    = (32'(cfg_row_shift) > MAX_ROW_SHIFT);
    assign shift_clamped = shift_over ? SHW'(MAX_ROW_SHIFT) : cfg_row_shift;
    assign cfg_ready     = rst_n && cfg_take;
    assign cfg_hs        = cfg_valid && cfg_ready;
    assign cfg_err       = cfg_err_q;

    always_comb begin
        cfg_d.act_src   = src_e'(cfg_act_src);
        cfg_d.row_shift = CFG_SHIFT_W'(shift_clamped);
        cfg_d.w_src     = src_e'(cfg_w_src);
    end

    // A pending config in IDLE takes priority over a new activation that cycle.
    assign act_gate     = rst_n && (state_q != StDrain) && !((state_q == StIdle) && cfg_valid);
    assign act_in_ready = skid_in_ready && act_gate;
    assign act_hs       = act_in_valid && act_in_ready;

    always_comb begin : route_comb
        int unsigned idx;
        routed = '0;
        for (int unsigned r = 0; r < NUM_PE_ROW; r++) begin
            idx = r + 32'(cfg_q.row_shift);
            if (idx >= NUM_PE_ROW) begin
                idx = idx - NUM_PE_ROW;
            end
            if (cfg_q.act_src == SRC_BUF) begin
                routed[r*AL +: AL] = act_buf_in[idx*AL +: AL];
            end else begin
                routed[r*AL +: AL] = act_dummy_in[r*AL +: AL];
            end
        end
    end

    pe_act_skid_buffer #(
        .Width (ARW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (routed),
        .in_valid  (act_in_valid && act_gate),
        .in_ready  (skid_in_ready),
        .out_data  (pe_act_out),
        .out_valid (pe_act_valid),
        .out_ready (pe_act_ready),
        .count     (skid_count)
    );

    always_comb begin
        state_d  = state_q;
        cfg_take = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    cfg_take = 1'b1;
                end else if (act_hs) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cfg_valid) begin
                    state_d = StDrain;
                end else if ((skid_count == 2'd0) && !act_hs) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if ((skid_count == 2'd0) && !w_load_q) begin
                    cfg_take = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cfg_q     <= '{act_src: SRC_DUMMY, row_shift: '0, w_src: SRC_DUMMY};
            cfg_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cfg_hs) begin
                cfg_q <= cfg_d;
                if (shift_over) begin
                    cfg_err_q <= 1'b1;
                end
            end
        end
    end

    // Weight path: whole-vector select keeps column c of each source on column c.
    assign w_in_ready = rst_n && (state_q != StDrain);
    assign w_hs       = w_in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_load_q <= 1'b0;
            wreg_q   <= '0;
            wbpr_q   <= '0;
            wetc_q   <= '0;
            shadow_q <= '0;
        end else begin
            w_load_q <= w_hs;
            if (w_hs) begin
                if (cfg_q.w_src == SRC_BUF) begin
                    wreg_q   <= w_buf_reg;
                    wbpr_q   <= w_buf_bpr;
                    wetc_q   <= w_buf_etc;
                    shadow_q <= w_buf_shadow;
                end else begin
                    wreg_q   <= w_dummy_reg;
                    wbpr_q   <= w_dummy_bpr;
                    wetc_q   <= w_dummy_etc;
                    shadow_q <= w_dummy_shadow;
                end
            end
        end
    end

    assign pe_wreg            = wreg_q;
    assign pe_wbpr            = wbpr_q;
    assign pe_wetc            = wetc_q;
    assign pe_shadow_afifo_in = shadow_q;
    assign pe_w_load          = w_load_q;

`ifdef ROUTER_PERF_CNT_EN
    logic [31:0] beats_q, stalls_q, drain_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beats_q  <= '0;
            stalls_q <= '0;
            drain_q  <= '0;
        end else begin
            if (pe_act_valid && pe_act_ready && (beats_q != '1)) begin
                beats_q <= beats_q + 32'd1;
            end
            if (pe_act_valid && !pe_act_ready && (stalls_q != '1)) begin
                stalls_q <= stalls_q + 32'd1;
            end
            if ((state_q == StDrain) && (drain_q != '1)) begin
                drain_q <= drain_q + 32'd1;
            end
        end
    end

    assign perf_act_beats  = beats_q;
    assign perf_act_stalls = stalls_q;
    assign perf_cfg_drain  = drain_q;
`endif

endmodule

// File: tb/tb_pe_array_data_in_router.sv
// Directed self-checking bench for pe_array_data_in_router (MAX_ROW_SHIFT=2 to reach the clamp).
// Perf counter checks run only when ROUTER_PERF_CNT_EN is defined.
module tb_pe_array_data_in_router;

    localparam int ROW  = 16;
    localparam int COL  = 16;
    localparam int T    = 11;
    localparam int AW   = 16;
    localparam int WW   = 16;
    localparam int EW   = 4;
    localparam int MAXS = 2;
    localparam int SHW  = $clog2(MAXS + 1);
    localparam int AL   = AW + 1;
    localparam int BPRW = ((WW + 1) / 2) * 3;
    localparam int ARW  = ROW * AL;
    localparam int WRW  = COL * WW * T;
    localparam int BRW  = COL * BPRW * T;
    localparam int ERW  = COL * EW * T;
    localparam int SRW  = COL * AL;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cfg_valid, cfg_ready, cfg_act_src, cfg_w_src, cfg_err;
    logic [SHW-1:0] cfg_row_shift;
    logic [ARW-1:0] act_dummy_in, act_buf_in, pe_act_out;
    logic           act_in_valid, act_in_ready, pe_act_valid, pe_act_ready;
    logic [WRW-1:0] w_dummy_reg, w_buf_reg, pe_wreg;
    logic [BRW-1:0] w_dummy_bpr, w_buf_bpr, pe_wbpr;
    logic [ERW-1:0] w_dummy_etc, w_buf_etc, pe_wetc;
    logic [SRW-1:0] w_dummy_shadow, w_buf_shadow, pe_shadow_afifo_in;
    logic           w_in_valid, w_in_ready, pe_w_load;
`ifdef ROUTER_PERF_CNT_EN
    logic [31:0]    perf_act_beats, perf_act_stalls, perf_cfg_drain;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pe_array_data_in_router #(
        .NUM_PE_ROW    (ROW),
        .NUM_PE_COL    (COL),
        .NB_TAPS       (T),
        .ACT_WIDTH     (AW),
        .WEIGHT_WIDTH  (WW),
        .ETC_WIDTH     (EW),
        .MAX_ROW_SHIFT (MAXS)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cfg_valid          (cfg_valid),
        .cfg_ready          (cfg_ready),
        .cfg_act_src        (cfg_act_src),
        .cfg_row_shift      (cfg_row_shift),
        .cfg_w_src          (cfg_w_src),
        .cfg_err            (cfg_err),
        .act_dummy_in       (act_dummy_in),
        .act_buf_in         (act_buf_in),
        .act_in_valid       (act_in_valid),
        .act_in_ready       (act_in_ready),
        .pe_act_out         (pe_act_out),
        .pe_act_valid       (pe_act_valid),
        .pe_act_ready       (pe_act_ready),
        .w_dummy_reg        (w_dummy_reg),
        .w_dummy_bpr        (w_dummy_bpr),
        .w_dummy_etc        (w_dummy_etc),
        .w_dummy_shadow     (w_dummy_shadow),
        .w_buf_reg          (w_buf_reg),
        .w_buf_bpr          (w_buf_bpr),
        .w_buf_etc          (w_buf_etc),
        .w_buf_shadow       (w_buf_shadow),
        .w_in_valid         (w_in_valid),
        .w_in_ready         (w_in_ready),
        .pe_wreg            (pe_wreg),
        .pe_wbpr            (pe_wbpr),
        .pe_wetc            (pe_wetc),
        .pe_shadow_afifo_in (pe_shadow_afifo_in),
        .pe_w_load          (pe_w_load)
`ifdef ROUTER_PERF_CNT_EN
        ,
        .perf_act_beats     (perf_act_beats),
        .perf_act_stalls    (perf_act_stalls),
        .perf_cfg_drain     (perf_cfg_drain)
`endif
    );

    // Lane r = base + r.
    function automatic logic [ARW-1:0] mk_act(input int base);
        logic [ARW-1:0] v;
        for (int r = 0; r < ROW; r++) v[r*AL +: AL] = AL'(base + r);
        return v;
    endfunction

    // Expected buffer routing of mk_act(base) rotated by sh rows.
    function automatic logic [ARW-1:0] rot_exp(input int base, input int sh);
        logic [ARW-1:0] v;
        for (int r = 0; r < ROW; r++) v[r*AL +: AL] = AL'(base + ((r + sh) % ROW));
        return v;
    endfunction

    task automatic apply_cfg(input logic a, input logic [SHW-1:0] s, input logic w);
        bit done = 1'b0;
        cfg_valid = 1'b1; cfg_act_src = a; cfg_row_shift = s; cfg_w_src = w;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (cfg_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL cfg_timeout: cfg_ready stayed 0 for 20 cycles, expected 1");
        end
    endtask

    task automatic send_act(input logic [ARW-1:0] buf_v, input logic [ARW-1:0] dummy_v);
        bit done = 1'b0;
        act_buf_in = buf_v; act_dummy_in = dummy_v; act_in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (act_in_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        act_in_valid = 1'b0;
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL act_timeout: act_in_ready stayed 0 for 50 cycles, expected 1");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_valid = 1'b1; act_in_valid = 1'b1; w_in_valid = 1'b1; pe_act_ready = 1'b1;
        act_buf_in = mk_act(1); act_dummy_in = mk_act(2);
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (pe_act_valid !== 1'b0) begin miscompares++; $display("FAIL rst_act_valid: got %b, expected 0", pe_act_valid); end
        vectors++; if (pe_act_out !== '0) begin miscompares++; $display("FAIL rst_act_out: got %h, expected 0", pe_act_out); end
        vectors++; if (pe_w_load !== 1'b0) begin miscompares++; $display("FAIL rst_w_load: got %b, expected 0", pe_w_load); end
        vectors++; if (pe_wreg !== '0 || pe_shadow_afifo_in !== '0) begin miscompares++; $display("FAIL rst_weights: nonzero weight outputs, expected 0"); end
        vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL rst_cfg_err: got %b, expected 0", cfg_err); end
        vectors++; if (act_in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_act_in_ready: got %b, expected 0", act_in_ready); end
        vectors++; if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL rst_cfg_ready: got %b, expected 0", cfg_ready); end
        vectors++; if (w_in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_w_in_ready: got %b, expected 0", w_in_ready); end
        cfg_valid = 1'b0; act_in_valid = 1'b0; w_in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (act_in_ready !== 1'b1) begin miscompares++; $display("FAIL idle_act_in_ready: got %b, expected 1", act_in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_rotation();
        apply_cfg(1'b1, 2'd2, 1'b0);
        pe_act_ready = 1'b1;
        send_act(mk_act(0), mk_act(100));
        @(negedge clk);
        vectors++; if (pe_act_valid !== 1'b1) begin miscompares++; $display("FAIL rot_latency: pe_act_valid got %b, expected 1", pe_act_valid); end
        vectors++; if (pe_act_out[14*AL +: AL] !== 17'd0) begin miscompares++; $display("FAIL rot_lane14: got %0d, expected 0", pe_act_out[14*AL +: AL]); end
        vectors++; if (pe_act_out[15*AL +: AL] !== 17'd1) begin miscompares++; $display("FAIL rot_lane15: got %0d, expected 1", pe_act_out[15*AL +: AL]); end
        vectors++; if (pe_act_out[0 +: AL] !== 17'd2) begin miscompares++; $display("FAIL rot_lane0: got %0d, expected 2", pe_act_out[0 +: AL]); end
        vectors++; if (pe_act_out !== rot_exp(0, 2)) begin miscompares++; $display("FAIL rot_vector: got %h, expected %h", pe_act_out, rot_exp(0, 2)); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if (pe_act_valid !== 1'b0) begin miscompares++; $display("FAIL rot_drained: pe_act_valid got %b, expected 0", pe_act_valid); end
        @(posedge clk); #1;
        // Dummy source ignores the row shift.
        apply_cfg(1'b0, 2'd2, 1'b0);
        send_act(mk_act(0), mk_act(100));
        @(negedge clk);
        vectors++; if (pe_act_out !== mk_act(100)) begin miscompares++; $display("FAIL dummy_vector: got %h, expected %h", pe_act_out, mk_act(100)); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int got = 0;
        logic stalled = 1'b0;
        logic [ARW-1:0] held = '0;
        apply_cfg(1'b1, 2'd0, 1'b0);
        fork
            begin
                for (int i = 0; i < 10; i++) send_act(mk_act(i * 32), mk_act(7));
            end
            begin
                for (int k = 0; k < 200 && got < 10; k++) begin
                    pe_act_ready = (k % 3 == 0);
                    @(negedge clk);
                    if (stalled) begin
                        vectors++;
                        if (pe_act_valid !== 1'b1 || pe_act_out !== held) begin
                            miscompares++;
                            $display("FAIL bp_stable: got %h, expected held %h", pe_act_out, held);
                        end
                    end
                    stalled = 1'b0;
                    if (pe_act_valid) begin
                        if (pe_act_ready) begin
                            vectors++;
                            if (pe_act_out !== mk_act(got * 32)) begin
                                miscompares++;
                                $display("FAIL bp_order%0d: got %h, expected %h", got, pe_act_out, mk_act(got * 32));
                            end
                            got++;
                        end else begin
                            stalled = 1'b1;
                            held = pe_act_out;
                        end
                    end
                    @(posedge clk); #1;
                end
            end
        join
        vectors++; if (got != 10) begin miscompares++; $display("FAIL bp_count: got %0d beats, expected 10", got); end
        pe_act_ready = 1'b1;
        @(negedge clk);
        vectors++; if (pe_act_valid !== 1'b0) begin miscompares++; $display("FAIL bp_no_dup: pe_act_valid got %b, expected 0", pe_act_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_drain();
        apply_cfg(1'b1, 2'd0, 1'b0);
        pe_act_ready = 1'b0;
        send_act(mk_act(0), mk_act(7));
        send_act(mk_act(200), mk_act(7));
        cfg_valid = 1'b1; cfg_act_src = 1'b1; cfg_row_shift = 2'd1; cfg_w_src = 1'b0;
        @(negedge clk);
        vectors++; if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL drain_run_ready: cfg_ready got %b, expected 0", cfg_ready); end
        @(posedge clk); #1;
        pe_act_ready = 1'b1;
        @(negedge clk);
        vectors++; if (pe_act_out !== mk_act(0) || cfg_ready !== 1'b0) begin miscompares++; $display("FAIL drain_beat0: got %h ready %b, expected %h ready 0", pe_act_out, cfg_ready, mk_act(0)); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if (pe_act_out !== mk_act(200) || cfg_ready !== 1'b0) begin miscompares++; $display("FAIL drain_beat1: got %h ready %b, expected %h ready 0", pe_act_out, cfg_ready, mk_act(200)); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL drain_cfg_ready: got %b, expected 1", cfg_ready); end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        send_act(mk_act(0), mk_act(7));
        @(negedge clk);
        vectors++; if (pe_act_out !== rot_exp(0, 1)) begin miscompares++; $display("FAIL drain_new_cfg: got %h, expected %h", pe_act_out, rot_exp(0, 1)); end
        @(posedge clk); #1;
    endtask

    task automatic test_weights();
        for (int c = 0; c < COL; c++) begin
            for (int t = 0; t < T; t++) begin
                w_buf_reg[(c*T+t)*WW +: WW]       = WW'(c * 256 + t);
                w_dummy_reg[(c*T+t)*WW +: WW]     = WW'(32768 + c * 16 + t);
                w_buf_bpr[(c*T+t)*BPRW +: BPRW]   = BPRW'(c * 1000 + t + 1);
                w_dummy_bpr[(c*T+t)*BPRW +: BPRW] = BPRW'(c * 1000 + t + 500000);
                w_buf_etc[(c*T+t)*EW +: EW]       = EW'(c + t);
                w_dummy_etc[(c*T+t)*EW +: EW]     = EW'(15 - ((c + t) % 16));
            end
            w_buf_shadow[c*AL +: AL]   = AL'(4096 + c);
            w_dummy_shadow[c*AL +: AL] = AL'(8192 + c);
        end
        w_buf_reg[(3*T)*WW +: WW] = 16'hABCD;
        apply_cfg(1'b1, 2'd0, 1'b1);
        w_in_valid = 1'b1;
        @(negedge clk);
        vectors++; if (w_in_ready !== 1'b1) begin miscompares++; $display("FAIL w_in_ready: got %b, expected 1", w_in_ready); end
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (pe_w_load !== 1'b1) begin miscompares++; $display("FAIL w_load_pulse: got %b, expected 1", pe_w_load); end
        vectors++; if (pe_wreg[(3*T)*WW +: WW] !== 16'hABCD) begin miscompares++; $display("FAIL w_col3: got %h, expected abcd", pe_wreg[(3*T)*WW +: WW]); end
        for (int c = 0; c < COL; c++) begin
            vectors++;
            if (pe_wreg[c*T*WW +: T*WW] !== w_buf_reg[c*T*WW +: T*WW] ||
                pe_wbpr[c*T*BPRW +: T*BPRW] !== w_buf_bpr[c*T*BPRW +: T*BPRW] ||
                pe_wetc[c*T*EW +: T*EW] !== w_buf_etc[c*T*EW +: T*EW]) begin
                miscompares++;
                $display("FAIL w_buf_col%0d: reg got %h, expected %h", c, pe_wreg[c*T*WW +: T*WW], w_buf_reg[c*T*WW +: T*WW]);
            end
            vectors++;
            if (pe_shadow_afifo_in[c*AL +: AL] !== AL'(4096 + c)) begin
                miscompares++;
                $display("FAIL shadow_col%0d: got %0d, expected %0d", c, pe_shadow_afifo_in[c*AL +: AL], 4096 + c);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if (pe_w_load !== 1'b0) begin miscompares++; $display("FAIL w_load_single: got %b, expected 0", pe_w_load); end
        vectors++; if (pe_wreg[(3*T)*WW +: WW] !== 16'hABCD) begin miscompares++; $display("FAIL w_hold: got %h, expected abcd", pe_wreg[(3*T)*WW +: WW]); end
        @(posedge clk); #1;
        apply_cfg(1'b1, 2'd0, 1'b0);
        w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        @(negedge clk);
        for (int c = 0; c < COL; c++) begin
            vectors++;
            if (pe_wreg[c*T*WW +: T*WW] !== w_dummy_reg[c*T*WW +: T*WW] ||
                pe_shadow_afifo_in[c*AL +: AL] !== AL'(8192 + c)) begin
                miscompares++;
                $display("FAIL w_dummy_col%0d: shadow got %0d, expected %0d", c, pe_shadow_afifo_in[c*AL +: AL], 8192 + c);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clamp();
        @(negedge clk);
        vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL clamp_pre_err: got %b, expected 0", cfg_err); end
        @(posedge clk); #1;
        apply_cfg(1'b1, 2'd3, 1'b0);
        pe_act_ready = 1'b1;
        @(negedge clk);
        vectors++; if (cfg_err !== 1'b1) begin miscompares++; $display("FAIL clamp_err: got %b, expected 1", cfg_err); end
        @(posedge clk); #1;
        send_act(mk_act(0), mk_act(7));
        @(negedge clk);
        vectors++; if (pe_act_out !== rot_exp(0, 2)) begin miscompares++; $display("FAIL clamp_shift: got %h, expected %h", pe_act_out, rot_exp(0, 2)); end
        @(posedge clk); #1;
        apply_cfg(1'b1, 2'd1, 1'b0);
        @(negedge clk);
        vectors++; if (cfg_err !== 1'b1) begin miscompares++; $display("FAIL clamp_sticky: got %b, expected 1", cfg_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_flush();
        pe_act_ready = 1'b0;
        send_act(mk_act(5), mk_act(7));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (pe_act_valid !== 1'b0 || pe_act_out !== '0) begin miscompares++; $display("FAIL flush_act: valid %b out %h, expected 0 0", pe_act_valid, pe_act_out); end
        vectors++; if (cfg_err !== 1'b0 || pe_wreg !== '0) begin miscompares++; $display("FAIL flush_state: cfg_err %b, expected 0 and cleared weights", cfg_err); end
        @(posedge clk); #1;
    endtask

`ifdef ROUTER_PERF_CNT_EN
    task automatic test_perf();
        @(negedge clk);
        vectors++; if (perf_act_beats !== 0 || perf_act_stalls !== 0 || perf_cfg_drain !== 0) begin miscompares++; $display("FAIL perf_reset: %0d %0d %0d, expected 0 0 0", perf_act_beats, perf_act_stalls, perf_cfg_drain); end
        @(posedge clk); #1;
        pe_act_ready = 1'b0;
        send_act(mk_act(0), mk_act(7));
        repeat (5) @(posedge clk);
        #1;
        pe_act_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if (perf_act_stalls !== 32'd5) begin miscompares++; $display("FAIL perf_stalls: got %0d, expected 5", perf_act_stalls); end
        vectors++; if (perf_act_beats !== 32'd1) begin miscompares++; $display("FAIL perf_beats: got %0d, expected 1", perf_act_beats); end
        vectors++; if (perf_cfg_drain !== 32'd0) begin miscompares++; $display("FAIL perf_drain: got %0d, expected 0", perf_cfg_drain); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cfg_valid = 1'b0; cfg_act_src = 1'b0; cfg_row_shift = '0; cfg_w_src = 1'b0;
        act_dummy_in = '0; act_buf_in = '0; act_in_valid = 1'b0; pe_act_ready = 1'b0;
        w_dummy_reg = '0; w_dummy_bpr = '0; w_dummy_etc = '0; w_dummy_shadow = '0;
        w_buf_reg = '0; w_buf_bpr = '0; w_buf_etc = '0; w_buf_shadow = '0; w_in_valid = 1'b0;
        test_reset();
        test_rotation();
        test_backpressure();
        test_drain();
        test_weights();
        test_clamp();
        test_reset_flush();
`ifdef ROUTER_PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
